// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous-FIFO write port between N producers,
// with a reservation counter so grants never target a full FIFO. Option: FIFO_ARB_HIPRI_EN.
module fifo_wr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 req,
    input  logic [N*WIDTH-1:0]           req_data,
    output logic [N-1:0]                 gnt,
    output logic                         fifo_write_en,
    output logic [WIDTH-1:0]             fifo_data_in,
    input  logic                         fifo_read_en,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]    ptr_r;
    logic [LW-1:0]    level_r;
    logic             write_en_r;
    logic [WIDTH-1:0] data_r;
    logic             overflow_r;

    logic             space_s;
    logic             found_s;
    logic [PW-1:0]    gidx_s;
    logic [PW-1:0]    ptr_nxt_s;
    logic [PW:0]      pick_s;
    logic [N-1:0]     gnt_s;
    logic             inc_s;
    logic             dec_s;

    // First requester at or after p, wrapping; returns {found, index}.
    function automatic logic [PW:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
        logic [PW:0] res;
        int          idx;
        res = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(p) + k) % N;
            if (!res[PW] && r[idx]) begin
                res = {1'b1, PW'(idx)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Grant selection, pointer advance and level inc/dec qualifiers.
    always_comb begin
        space_s   = (level_r < LW'(DEPTH)) && !fifo_full;
        pick_s    = rr_pick(req, ptr_r);
        found_s   = 1'b0;
        gidx_s    = '0;
        gnt_s     = '0;
        ptr_nxt_s = ptr_r;
        if (space_s && !rst) begin
`ifdef FIFO_ARB_HIPRI_EN
            if (req[0]) begin
                found_s = 1'b1;
                gidx_s  = '0;
            end else begin
                found_s = pick_s[PW];
                gidx_s  = pick_s[PW-1:0];
            end
`else
            found_s = pick_s[PW];
            gidx_s  = pick_s[PW-1:0];
`endif
        end else begin
            found_s = 1'b0;
        end
        if (found_s) begin
            gnt_s = N'(1) << gidx_s;
`ifdef FIFO_ARB_HIPRI_EN
            // Requester 0 grants leave the rotation of 1..N-1 untouched.
            if (gidx_s == '0) begin
                ptr_nxt_s = ptr_r;
            end else if (gidx_s == PW'(N - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = gidx_s + PW'(1);
            end
`else
            if (gidx_s == PW'(N - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = gidx_s + PW'(1);
            end
`endif
        end else begin
            ptr_nxt_s = ptr_r;
        end
        inc_s = found_s;
        dec_s = fifo_read_en && !fifo_empty && (level_r != '0);
    end

    // Pointer, write stage, reservation level and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r      <= '0;
            level_r    <= '0;
            write_en_r <= 1'b0;
            data_r     <= '0;
            overflow_r <= 1'b0;
        end else begin
            ptr_r      <= ptr_nxt_s;
            write_en_r <= inc_s;
            if (inc_s) begin
                data_r <= req_data[int'(gidx_s)*WIDTH +: WIDTH];
            end
            case ({inc_s, dec_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
            if (write_en_r && fifo_full) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign gnt           = gnt_s;
    assign fifo_write_en = write_en_r;
    assign fifo_data_in  = data_r;
    assign level         = level_r;
    assign overflow_err  = overflow_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural FIFO occupancy, grant/level model
// and a data scoreboard queue checked on each FIFO write.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]      gnt;
    logic              fifo_write_en;
    logic [WIDTH-1:0]  fifo_data_in;
    logic              fifo_read_en;
    logic              fifo_full;
    logic              fifo_empty;
    logic [4:0]        level;
    logic              overflow_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             mptr;
    int             mlevel;
    bit             mwe;
    bit             mov;
    int             fcnt;
    logic [WIDTH-1:0] q[$];
    logic [N-1:0]   g_seen;
    int             ngr;

    fifo_wr_arbiter #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_write_en(fifo_write_en), .fifo_data_in(fifo_data_in),
        .fifo_read_en(fifo_read_en), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .level(level), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] exp_gnt(input logic [N-1:0] r, input int p, input bit sp);
        if (!sp) return '0;
`ifdef FIFO_ARB_HIPRI_EN
        if (r[0]) return 4'b0001;
`endif
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return 4'b0001 << ((p + k) % N);
        end
        return '0;
    endfunction

    // One clock cycle, entered and left at the falling edge.
    task automatic cycle(input logic [N-1:0] r, input logic rd, input logic ff);
        logic [N-1:0] eg;
        int  gi;
        bit  sp, dec;
        req          = r;
        fifo_read_en = rd;
        fifo_full    = ff || (fcnt == DEPTH);
        fifo_empty   = (fcnt == 0);
        #1;
        sp = (mlevel < DEPTH) && !fifo_full;
        eg = exp_gnt(r, mptr, sp);
        g_seen = gnt;
        chk("gnt", gnt, eg);
        chk("write_en", fifo_write_en, mwe);
        if (mwe) begin
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) chk("data_in", fifo_data_in, q.pop_front());
        end
        chk("level", level, mlevel);
        chk("overflow", overflow_err, mov);
        gi = -1;
        for (int k = 0; k < N; k++) if (eg[k]) gi = k;
        dec = rd && !fifo_empty;
        if (mwe && fifo_full) mov = 1;
        fcnt = fcnt + ((mwe && (fcnt < DEPTH || dec)) ? 1 : 0) - (dec ? 1 : 0);
        if (gi >= 0) begin
            q.push_back(req_data[gi*WIDTH +: WIDTH]);
            ngr++;
`ifdef FIFO_ARB_HIPRI_EN
            if (gi != 0) mptr = (gi + 1) % N;
`else
            mptr = (gi + 1) % N;
`endif
        end
        mlevel = mlevel + ((gi >= 0) ? 1 : 0) - ((dec && mlevel > 0) ? 1 : 0);
        mwe = (gi >= 0);
        @(negedge clk);
    endtask

    task automatic model_reset();
        mptr = 0; mlevel = 0; mwe = 0; mov = 0; fcnt = 0; q.delete();
    endtask

    initial begin
        // Reset with everyone requesting
        rst = 1'b1; req = 4'b1111; req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        fifo_read_en = 1'b0; fifo_full = 1'b0; fifo_empty = 1'b1;
        model_reset(); ngr = 0;
        #8;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_we", fifo_write_en, 1'b0);
        chk("rst_level", level, 5'd0);
        chk("rst_ov", overflow_err, 1'b0);
        chk("rst_data", fifo_data_in, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Rotation: 8 grants 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b0, 1'b0);
`ifndef FIFO_ARB_HIPRI_EN
            chk("rotation", g_seen, 4'b0001 << (i % 4));
`endif
        end
        chk("level_8", level, 5'd8);

        // Simultaneous grant and read at level 8
        cycle(4'b1111, 1'b1, 1'b0);
        chk("balance_level", level, 5'd8);

        // Fill: exactly 8 more grants to reach 16, then none
        ngr = 0;
        for (int i = 0; i < 12; i++) begin
            req_data = $urandom;
            cycle(4'b1111, 1'b0, 1'b0);
        end
        chk("fill_grants", ngr, 8);
        chk("full_level", level, 5'd16);
        chk("full_gnt", g_seen, 4'b0000);

        // Read at full: one grant next cycle, level back to 16
        cycle(4'b1111, 1'b1, 1'b0);
        chk("read_at_full_gnt0", g_seen, 4'b0000);
        cycle(4'b1111, 1'b0, 1'b0);
        chk("after_read_onehot", (g_seen != 0) && ((g_seen & (g_seen - 1)) == 0), 1'b1);
        cycle(4'b1111, 1'b0, 1'b0);
        chk("refull_gnt", g_seen, 4'b0000);
        chk("refull_level", level, 5'd16);

        // Drain, then skip-idle requesters from ptr=1
        for (int i = 0; i < 10; i++) cycle(4'b0000, 1'b1, 1'b0);
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        cycle(4'b0001, 1'b0, 1'b0);
        cycle(4'b0101, 1'b0, 1'b0);
`ifndef FIFO_ARB_HIPRI_EN
        chk("skip1", g_seen, 4'b0100);
`endif
        cycle(4'b0101, 1'b0, 1'b0);
`ifndef FIFO_ARB_HIPRI_EN
        chk("skip2", g_seen, 4'b0001);
`endif
        cycle(4'b0101, 1'b0, 1'b0);
`ifndef FIFO_ARB_HIPRI_EN
        chk("skip3", g_seen, 4'b0100);
`endif
        cycle(4'b0000, 1'b0, 1'b0);

        // Overflow: registered write lands while FIFO reports full
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1000, 1'b0, 1'b0);
        chk("overflow_set", overflow_err, 1'b1);
        cycle(4'b0000, 1'b0, 1'b0);
        chk("overflow_sticky", overflow_err, 1'b1);

        // Reset mid-operation drops the in-flight write
        cycle(4'b0001, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_we", fifo_write_en, 1'b0);
        chk("midrst_level", level, 5'd0);
        chk("midrst_ov", overflow_err, 1'b0);
        chk("midrst_gnt", gnt, 4'b0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

`ifdef FIFO_ARB_HIPRI_EN
        // Strict priority for requester 0, then 1,2,3 in order
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 1'b0, 1'b0);
            chk("hipri0", g_seen, 4'b0001);
        end
        cycle(4'b1110, 1'b0, 1'b0);
        chk("hipri_rr1", g_seen, 4'b0010);
        cycle(4'b1110, 1'b0, 1'b0);
        chk("hipri_rr2", g_seen, 4'b0100);
        cycle(4'b1110, 1'b0, 1'b0);
        chk("hipri_rr3", g_seen, 4'b1000);
`else
        for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b0, 1'b0);
`endif
        cycle(4'b0000, 1'b0, 1'b0);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
